// File: rtl/axi_io_pmp_gate.sv
// rtl/axi_io_pmp_gate.sv - IO-PMP enforcement gate between a DMA-side AXI port and memory
// Denied AW/AR are absorbed locally and answered with in-order error responses.
package axi_io_pmp_gate_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
    logic        user;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        user;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } axi_rsp_t;
endpackage

module axi_io_pmp_gate #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter logic [1:0]  ERR_RESP        = 2'b10,
  parameter type         axi_req_t       = axi_io_pmp_gate_pkg::axi_req_t,
  parameter type         axi_rsp_t       = axi_io_pmp_gate_pkg::axi_rsp_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  axi_req_t              slv_req_i,
  output axi_rsp_t              slv_rsp_o,
  output axi_req_t              mst_req_o,
  input  axi_rsp_t              mst_rsp_i,
  output logic [ADDR_WIDTH-1:0] chk_aw_addr_o,
  input  logic                  chk_aw_allow_i,
  output logic [ADDR_WIDTH-1:0] chk_ar_addr_o,
  input  logic                  chk_ar_allow_i,
  output logic                  err_irq_o
);
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BIW = $bits(mst_rsp_i.b.id);
  localparam int unsigned RIW = $bits(mst_rsp_i.r.id);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {W_IDLE, W_FWD, W_DRAIN, W_ERR_WAIT, W_ERR_B} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ERR_WAIT, R_ERR} r_state_e;

  w_state_e       w_state_q, w_state_d;
  r_state_e       r_state_q, r_state_d;
  logic [CW-1:0]  wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [7:0]     bcnt_q, bcnt_d;
  logic [BIW-1:0] b_id_q, b_id_d;
  logic [RIW-1:0] r_id_q, r_id_d;

  logic w_idle, r_idle, aw_fwd, aw_deny, ar_fwd, ar_deny;
  logic aw_hs_mst, ar_hs_mst, b_hs_mst, r_last_hs_mst, w_last_hs;

  assign chk_aw_addr_o = slv_req_i.aw.addr;
  assign chk_ar_addr_o = slv_req_i.ar.addr;

  // Channel steering: payloads pass through, handshakes are gated by FSM state.
  always_comb begin
    mst_req_o = slv_req_i;
    slv_rsp_o = mst_rsp_i;

    w_idle  = (w_state_q == W_IDLE);
    r_idle  = (r_state_q == R_IDLE);
    aw_fwd  = rst_ni && w_idle && slv_req_i.aw_valid && chk_aw_allow_i && (wcnt_q < MAX_CNT);
    aw_deny = rst_ni && w_idle && slv_req_i.aw_valid && !chk_aw_allow_i;
    ar_fwd  = rst_ni && r_idle && slv_req_i.ar_valid && chk_ar_allow_i && (rcnt_q < MAX_CNT);
    ar_deny = rst_ni && r_idle && slv_req_i.ar_valid && !chk_ar_allow_i;

    mst_req_o.aw_valid = aw_fwd;
    slv_rsp_o.aw_ready = rst_ni && w_idle &&
                         (chk_aw_allow_i ? ((wcnt_q < MAX_CNT) && mst_rsp_i.aw_ready) : 1'b1);
    mst_req_o.ar_valid = ar_fwd;
    slv_rsp_o.ar_ready = rst_ni && r_idle &&
                         (chk_ar_allow_i ? ((rcnt_q < MAX_CNT) && mst_rsp_i.ar_ready) : 1'b1);

    mst_req_o.w_valid = rst_ni && (w_state_q == W_FWD) && slv_req_i.w_valid;
    slv_rsp_o.w_ready = rst_ni && (((w_state_q == W_FWD) && mst_rsp_i.w_ready) ||
                                   (w_state_q == W_DRAIN));

    if (w_state_q == W_ERR_B) begin
      slv_rsp_o.b_valid = rst_ni;
      slv_rsp_o.b       = '0;
      slv_rsp_o.b.id    = b_id_q;
      slv_rsp_o.b.resp  = ERR_RESP;
      mst_req_o.b_ready = 1'b0;
    end else begin
      slv_rsp_o.b_valid = rst_ni && mst_rsp_i.b_valid;
      mst_req_o.b_ready = rst_ni && slv_req_i.b_ready;
    end

    if (r_state_q == R_ERR) begin
      slv_rsp_o.r_valid = rst_ni;
      slv_rsp_o.r       = '0;
      slv_rsp_o.r.id    = r_id_q;
      slv_rsp_o.r.resp  = ERR_RESP;
      slv_rsp_o.r.last  = (bcnt_q == 8'd0);
      mst_req_o.r_ready = 1'b0;
    end else begin
      slv_rsp_o.r_valid = rst_ni && mst_rsp_i.r_valid;
      mst_req_o.r_ready = rst_ni && slv_req_i.r_ready;
    end

    aw_hs_mst     = aw_fwd && mst_rsp_i.aw_ready;
    ar_hs_mst     = ar_fwd && mst_rsp_i.ar_ready;
    b_hs_mst      = mst_rsp_i.b_valid && mst_req_o.b_ready;
    r_last_hs_mst = mst_rsp_i.r_valid && mst_req_o.r_ready && mst_rsp_i.r.last;
    w_last_hs     = slv_req_i.w_valid && slv_rsp_o.w_ready && slv_req_i.w.last;
    err_irq_o     = aw_deny || ar_deny;
  end

  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    b_id_d    = b_id_q;
    r_id_d    = r_id_q;
    bcnt_d    = bcnt_q;
    wcnt_d    = wcnt_q + CW'(aw_hs_mst) - CW'(b_hs_mst);
    rcnt_d    = rcnt_q + CW'(ar_hs_mst) - CW'(r_last_hs_mst);

    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs_mst) begin
          w_state_d = W_FWD;
        end else if (aw_deny) begin
          b_id_d    = slv_req_i.aw.id;
          w_state_d = W_DRAIN;
        end
      end
      W_FWD:      if (w_last_hs) w_state_d = W_IDLE;
      // Skip the wait state when nothing is outstanding so B follows wlast by one cycle.
      W_DRAIN:    if (w_last_hs) w_state_d = (wcnt_q == '0) ? W_ERR_B : W_ERR_WAIT;
      W_ERR_WAIT: if (wcnt_q == '0) w_state_d = W_ERR_B;
      W_ERR_B:    if (slv_req_i.b_ready) w_state_d = W_IDLE;
      default:    w_state_d = W_IDLE;
    endcase

    unique case (r_state_q)
      R_IDLE: begin
        if (ar_deny) begin
          r_id_d    = slv_req_i.ar.id;
          bcnt_d    = slv_req_i.ar.len;
          r_state_d = R_ERR_WAIT;
        end
      end
      R_ERR_WAIT: if (rcnt_q == '0) r_state_d = R_ERR;
      R_ERR: begin
        if (slv_req_i.r_ready) begin
          if (bcnt_q == 8'd0) begin
            r_state_d = R_IDLE;
          end else begin
            bcnt_d = bcnt_q - 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      bcnt_q    <= '0;
      b_id_q    <= '0;
      r_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      bcnt_q    <= bcnt_d;
      b_id_q    <= b_id_d;
      r_id_q    <= r_id_d;
    end
  end
endmodule

// File: tb/tb_axi_io_pmp_gate.sv
// tb/tb_axi_io_pmp_gate.sv - self-checking bench for axi_io_pmp_gate
// Per-cycle transaction model plus directed literal checks.
module tb_axi_io_pmp_gate;
  import axi_io_pmp_gate_pkg::*;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  axi_req_t    slv_req, mst_req;
  axi_rsp_t    slv_rsp, mst_rsp;
  logic [63:0] chk_aw_addr, chk_ar_addr;
  logic        aw_allow, ar_allow, err_irq;
  int          n_chk = 0;
  int          n_err = 0;

  // Model: outstanding counts, write/read phase, owed error response
  int          mw = 0, mr = 0, w_ph = 0, r_ph = 0, r_left = 0;
  logic [3:0]  b_err_id = '0, r_err_id = '0;

  axi_io_pmp_gate #(
    .ADDR_WIDTH(64), .MAX_OUTSTANDING(MAX), .ERR_RESP(2'b10),
    .axi_req_t(axi_req_t), .axi_rsp_t(axi_rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(slv_req), .slv_rsp_o(slv_rsp),
    .mst_req_o(mst_req), .mst_rsp_i(mst_rsp),
    .chk_aw_addr_o(chk_aw_addr), .chk_aw_allow_i(aw_allow),
    .chk_ar_addr_o(chk_ar_addr), .chk_ar_allow_i(ar_allow),
    .err_irq_o(err_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_r_valid(input string name);
    int k = 0;
    while (slv_rsp.r_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk(name, 64'(k < 20), 64'd1);
  endtask

  always @(negedge clk) begin
    logic wfree, rfree, e_awv, e_awr, e_wv, e_wr, e_bv, e_bmr, e_arv, e_arr, e_rv, e_rmr, e_irq;
    logic aw_hs, b_hs, ar_hs, rl_hs, wl_hs;
    if (!rst_n) begin
      chk("rst_mst_aw_valid", mst_req.aw_valid, 0);
      chk("rst_mst_w_valid",  mst_req.w_valid, 0);
      chk("rst_mst_ar_valid", mst_req.ar_valid, 0);
      chk("rst_mst_b_ready",  mst_req.b_ready, 0);
      chk("rst_mst_r_ready",  mst_req.r_ready, 0);
      chk("rst_aw_ready", slv_rsp.aw_ready, 0);
      chk("rst_w_ready",  slv_rsp.w_ready, 0);
      chk("rst_ar_ready", slv_rsp.ar_ready, 0);
      chk("rst_b_valid",  slv_rsp.b_valid, 0);
      chk("rst_r_valid",  slv_rsp.r_valid, 0);
      chk("rst_irq",      err_irq, 0);
      mw = 0; mr = 0; w_ph = 0; r_ph = 0; r_left = 0;
    end else begin
      wfree = (w_ph == 0);
      rfree = (r_ph == 0);
      e_awv = wfree && slv_req.aw_valid && aw_allow && (mw < MAX);
      e_awr = wfree && (aw_allow ? ((mw < MAX) && mst_rsp.aw_ready) : 1'b1);
      e_arv = rfree && slv_req.ar_valid && ar_allow && (mr < MAX);
      e_arr = rfree && (ar_allow ? ((mr < MAX) && mst_rsp.ar_ready) : 1'b1);
      e_wv  = (w_ph == 1) && slv_req.w_valid;
      e_wr  = (w_ph == 2) || ((w_ph == 1) && mst_rsp.w_ready);
      e_bv  = (w_ph == 4) ? 1'b1 : mst_rsp.b_valid;
      e_bmr = (w_ph == 4) ? 1'b0 : slv_req.b_ready;
      e_rv  = (r_ph == 2) ? 1'b1 : mst_rsp.r_valid;
      e_rmr = (r_ph == 2) ? 1'b0 : slv_req.r_ready;
      e_irq = (wfree && slv_req.aw_valid && !aw_allow) || (rfree && slv_req.ar_valid && !ar_allow);

      chk("chk_aw_addr", chk_aw_addr, slv_req.aw.addr);
      chk("chk_ar_addr", chk_ar_addr, slv_req.ar.addr);
      chk("mst_aw_valid", mst_req.aw_valid, e_awv);
      chk("aw_ready", slv_rsp.aw_ready, e_awr);
      chk("mst_ar_valid", mst_req.ar_valid, e_arv);
      chk("ar_ready", slv_rsp.ar_ready, e_arr);
      chk("mst_w_valid", mst_req.w_valid, e_wv);
      chk("w_ready", slv_rsp.w_ready, e_wr);
      chk("b_valid", slv_rsp.b_valid, e_bv);
      chk("mst_b_ready", mst_req.b_ready, e_bmr);
      chk("r_valid", slv_rsp.r_valid, e_rv);
      chk("mst_r_ready", mst_req.r_ready, e_rmr);
      chk("err_irq", err_irq, e_irq);
      if (e_awv) chk("mst_aw_addr", mst_req.aw.addr, slv_req.aw.addr);
      if (e_arv) chk("mst_ar_len", mst_req.ar.len, slv_req.ar.len);
      if (e_wv)  chk("mst_w_data", mst_req.w.data, slv_req.w.data);
      if (e_bv) begin
        if (w_ph == 4) begin
          chk("err_b_id", slv_rsp.b.id, b_err_id);
          chk("err_b_resp", slv_rsp.b.resp, 2'b10);
          chk("err_b_user", slv_rsp.b.user, 0);
        end else begin
          chk("b_id", slv_rsp.b.id, mst_rsp.b.id);
          chk("b_resp", slv_rsp.b.resp, mst_rsp.b.resp);
        end
      end
      if (e_rv) begin
        if (r_ph == 2) begin
          chk("err_r_id", slv_rsp.r.id, r_err_id);
          chk("err_r_data", slv_rsp.r.data, 0);
          chk("err_r_resp", slv_rsp.r.resp, 2'b10);
          chk("err_r_last", slv_rsp.r.last, r_left == 1);
        end else begin
          chk("r_data", slv_rsp.r.data, mst_rsp.r.data);
          chk("r_last", slv_rsp.r.last, mst_rsp.r.last);
        end
      end

      aw_hs = e_awv && mst_rsp.aw_ready;
      b_hs  = mst_rsp.b_valid && e_bmr;
      ar_hs = e_arv && mst_rsp.ar_ready;
      rl_hs = mst_rsp.r_valid && e_rmr && mst_rsp.r.last;
      wl_hs = slv_req.w_valid && e_wr && slv_req.w.last;
      case (w_ph)
        0: if (aw_hs) w_ph = 1;
           else if (slv_req.aw_valid && !aw_allow) begin w_ph = 2; b_err_id = slv_req.aw.id; end
        1: if (wl_hs) w_ph = 0;
        2: if (wl_hs) w_ph = (mw == 0) ? 4 : 3;
        3: if (mw == 0) w_ph = 4;
        4: if (slv_req.b_ready) w_ph = 0;
        default: w_ph = 0;
      endcase
      case (r_ph)
        0: if (slv_req.ar_valid && !ar_allow) begin
             r_ph = 1; r_err_id = slv_req.ar.id; r_left = int'(slv_req.ar.len) + 1;
           end
        1: if (mr == 0) r_ph = 2;
        2: if (slv_req.r_ready) begin r_left--; if (r_left == 0) r_ph = 0; end
        default: r_ph = 0;
      endcase
      mw = mw + int'(aw_hs) - int'(b_hs);
      mr = mr + int'(ar_hs) - int'(rl_hs);
    end
  end

  initial begin
    slv_req = '0; mst_rsp = '0; aw_allow = 1'b0; ar_allow = 1'b0; rst_n = 1'b0;
    mst_rsp.aw_ready = 1'b1; mst_rsp.w_ready = 1'b1; mst_rsp.ar_ready = 1'b1;
    slv_req.b_ready = 1'b1; slv_req.r_ready = 1'b1;
    step(2);
    chk("reset_aw_ready", slv_rsp.aw_ready, 0);
    chk("reset_mst_b_ready", mst_req.b_ready, 0);
    rst_n = 1'b1; #1;
    chk("idle_w_ready", slv_rsp.w_ready, 0);
    chk("idle_b_valid", slv_rsp.b_valid, 0);

    // Allowed read, 4 beats
    slv_req.ar.addr = 64'h1000; slv_req.ar.len = 8'd3; slv_req.ar.id = 4'd1;
    slv_req.ar_valid = 1'b1; ar_allow = 1'b1; #1;
    chk("t1_mst_ar_valid", mst_req.ar_valid, 1);
    chk("t1_ar_ready", slv_rsp.ar_ready, 1);
    chk("t1_mst_ar_addr", mst_req.ar.addr, 64'h1000);
    step(); slv_req.ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mst_rsp.r_valid = 1'b1; mst_rsp.r.id = 4'd1; mst_rsp.r.data = 64'hA0 + 64'(i);
      mst_rsp.r.last = (i == 3); #1;
      chk("t1_r_data", slv_rsp.r.data, 64'hA0 + 64'(i));
      step();
    end
    mst_rsp.r_valid = 1'b0; mst_rsp.r = '0;

    // Denied write id=5 len=1
    slv_req.aw = '0; slv_req.aw.id = 4'd5; slv_req.aw.len = 8'd1; slv_req.aw.addr = 64'h8000;
    slv_req.aw_valid = 1'b1; aw_allow = 1'b0; #1;
    chk("t2_aw_ready", slv_rsp.aw_ready, 1);
    chk("t2_irq", err_irq, 1);
    chk("t2_mst_aw_valid", mst_req.aw_valid, 0);
    step(); slv_req.aw_valid = 1'b0;
    slv_req.w.data = 64'h11; slv_req.w.last = 1'b0; slv_req.w_valid = 1'b1; #1;
    chk("t2_mst_w_valid", mst_req.w_valid, 0);
    chk("t2_w_ready", slv_rsp.w_ready, 1);
    step(); slv_req.w.data = 64'h22; slv_req.w.last = 1'b1; #1;
    chk("t2_b_not_yet", slv_rsp.b_valid, 0);
    step(); slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0; #1;
    chk("t2_b_valid", slv_rsp.b_valid, 1);
    chk("t2_b_id", slv_rsp.b.id, 5);
    chk("t2_b_resp", slv_rsp.b.resp, 2'b10);
    step(); #1;
    chk("t2_b_done", slv_rsp.b_valid, 0);

    // Denied read behind two outstanding
    slv_req.ar = '0; slv_req.ar.id = 4'd1; slv_req.ar.addr = 64'h2000;
    slv_req.ar_valid = 1'b1; ar_allow = 1'b1; step();
    slv_req.ar.id = 4'd2; slv_req.ar.addr = 64'h2100; step();
    slv_req.ar.id = 4'd3; slv_req.ar.len = 8'd2; slv_req.ar.addr = 64'h9000; ar_allow = 1'b0; #1;
    chk("t3_ar_ready", slv_rsp.ar_ready, 1);
    chk("t3_irq", err_irq, 1);
    step(); slv_req.ar_valid = 1'b0; ar_allow = 1'b1;
    step(3);
    chk("t3_no_early_r", slv_rsp.r_valid, 0);
    mst_rsp.r_valid = 1'b1; mst_rsp.r.id = 4'd1; mst_rsp.r.last = 1'b1; mst_rsp.r.data = 64'h5;
    step(); mst_rsp.r.id = 4'd2; step();
    mst_rsp.r_valid = 1'b0; mst_rsp.r = '0; #1;
    for (int b = 0; b < 3; b++) begin
      wait_r_valid("t3_r_timeout");
      chk("t3_r_data", slv_rsp.r.data, 0);
      chk("t3_r_resp", slv_rsp.r.resp, 2'b10);
      chk("t3_r_id", slv_rsp.r.id, 3);
      chk("t3_r_last", slv_rsp.r.last, b == 2);
      step();
    end
    #1; chk("t3_r_done", slv_rsp.r_valid, 0);

    // Full: two allowed AWs with B withheld, third stalls
    for (int i = 0; i < 2; i++) begin
      slv_req.aw = '0; slv_req.aw.id = 4'(i); slv_req.aw.addr = 64'h3000 + 64'(i * 256);
      slv_req.aw_valid = 1'b1; aw_allow = 1'b1; step();
      slv_req.aw_valid = 1'b0; slv_req.w.last = 1'b1; slv_req.w.data = 64'(i);
      slv_req.w_valid = 1'b1; step();
      slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    end
    slv_req.aw.id = 4'd2; slv_req.aw.addr = 64'h3200; slv_req.aw_valid = 1'b1; #1;
    chk("t4_full_aw_ready", slv_rsp.aw_ready, 0);
    chk("t4_full_mst_aw_valid", mst_req.aw_valid, 0);
    step(2);
    chk("t4_still_stalled", slv_rsp.aw_ready, 0);
    mst_rsp.b_valid = 1'b1; mst_rsp.b.id = 4'd0; mst_rsp.b.resp = 2'b00; #1;
    chk("t4_b_pass", slv_rsp.b_valid, 1);
    chk("t4_aw_ready_same_cycle", slv_rsp.aw_ready, 0);
    step(); mst_rsp.b_valid = 1'b0; #1;
    chk("t4_aw_fwd", mst_req.aw_valid, 1);
    chk("t4_aw_ready", slv_rsp.aw_ready, 1);
    step(); slv_req.aw_valid = 1'b0; slv_req.w.last = 1'b1; slv_req.w_valid = 1'b1;
    step(); slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    mst_rsp.b_valid = 1'b1; mst_rsp.b.id = 4'd1; step();
    mst_rsp.b.id = 4'd2; step(); mst_rsp.b_valid = 1'b0;

    // r_ready throttling on a denied single-beat read
    slv_req.r_ready = 1'b0;
    slv_req.ar = '0; slv_req.ar.id = 4'd7; slv_req.ar_valid = 1'b1; ar_allow = 1'b0;
    step(); slv_req.ar_valid = 1'b0; ar_allow = 1'b1;
    wait_r_valid("t5_r_timeout");
    for (int i = 0; i < 3; i++) begin
      chk("t5_r_valid", slv_rsp.r_valid, 1);
      chk("t5_r_id", slv_rsp.r.id, 7);
      chk("t5_r_resp", slv_rsp.r.resp, 2'b10);
      chk("t5_r_last", slv_rsp.r.last, 1);
      step();
    end
    slv_req.r_ready = 1'b1; step(); #1;
    chk("t5_r_done", slv_rsp.r_valid, 0);

    // Both directions denied in the same cycle
    slv_req.aw = '0; slv_req.aw.id = 4'd6; slv_req.aw_valid = 1'b1; aw_allow = 1'b0;
    slv_req.ar = '0; slv_req.ar.id = 4'd8; slv_req.ar_valid = 1'b1; ar_allow = 1'b0; #1;
    chk("t6_irq", err_irq, 1);
    chk("t6_aw_ready", slv_rsp.aw_ready, 1);
    chk("t6_ar_ready", slv_rsp.ar_ready, 1);
    step(); slv_req.aw_valid = 1'b0; slv_req.ar_valid = 1'b0; #1;
    chk("t6_irq_once", err_irq, 0);
    slv_req.w.last = 1'b1; slv_req.w_valid = 1'b1; step();
    slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0; #1;
    chk("t6_b_valid", slv_rsp.b_valid, 1);
    chk("t6_b_id", slv_rsp.b.id, 6);
    chk("t6_r_id", slv_rsp.r.id, 8);
    step(3);

    // Reset in the middle of a drain
    slv_req.aw = '0; slv_req.aw.id = 4'd9; slv_req.aw.len = 8'd3;
    slv_req.aw_valid = 1'b1; aw_allow = 1'b0; step();
    slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b1; slv_req.w.last = 1'b0; step();
    slv_req.w_valid = 1'b0; rst_n = 1'b0; #1;
    chk("t7_rst_w_ready", slv_rsp.w_ready, 0);
    step(2); rst_n = 1'b1; #1;
    chk("t7_idle_w_ready", slv_rsp.w_ready, 0);
    chk("t7_idle_b_valid", slv_rsp.b_valid, 0);
    slv_req.aw.id = 4'd4; slv_req.aw.addr = 64'h4000; slv_req.aw.len = 8'd0;
    aw_allow = 1'b1; slv_req.aw_valid = 1'b1; #1;
    chk("t7_mst_aw_valid", mst_req.aw_valid, 1);
    step(); slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
    slv_req.w.data = 64'h44; #1;
    chk("t7_mst_w_valid", mst_req.w_valid, 1);
    chk("t7_mst_w_data", mst_req.w.data, 64'h44);
    step(); slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    mst_rsp.b_valid = 1'b1; mst_rsp.b.id = 4'd4; mst_rsp.b.resp = 2'b00; #1;
    chk("t7_b_valid", slv_rsp.b_valid, 1);
    chk("t7_b_id", slv_rsp.b.id, 4);
    chk("t7_b_resp", slv_rsp.b.resp, 2'b00);
    step(); mst_rsp.b_valid = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
